// File: rtl/rgb_byte_packer.sv
// Packs an interleaved R,G,B byte stream into 24-bit pixels with a one-deep
// registered output, tagging each pixel with frame/line markers from row/col counters.
module rgb_byte_packer #(
    parameter int unsigned width  = 768,
    parameter int unsigned height = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_byte,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_red,
    output logic [7:0] m_green,
    output logic [7:0] m_blue,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_eol,
    output logic       m_eof,
    output logic       frame_done
);

    localparam int unsigned COL_W = (width  > 1) ? $clog2(width)  : 1;
    localparam int unsigned ROW_W = (height > 1) ? $clog2(height) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(width - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(height - 1);

    typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

    phase_t           phase_q, phase_d;
    logic [7:0]       red_hold, green_hold;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             s_hs, load, consume;
    logic             col_last, row_last;

    assign s_ready  = (phase_q != PH_B) | ~m_valid | m_ready;
    assign s_hs     = s_valid & s_ready;
    assign load     = s_hs & (phase_q == PH_B);
    assign consume  = m_valid & m_ready;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    always_comb begin
        phase_d = phase_q;
        if (s_hs) begin
            case (phase_q)
                PH_R:    phase_d = PH_G;
                PH_G:    phase_d = PH_B;
                default: phase_d = PH_R;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_R;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_hold   <= '0;
            green_hold <= '0;
        end else if (s_hs) begin
            if (phase_q == PH_R) red_hold   <= s_byte;
            if (phase_q == PH_G) green_hold <= s_byte;
        end
    end

    // A load always replaces the output, even on the edge that consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_red      <= '0;
            m_green    <= '0;
            m_blue     <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            frame_done <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            frame_done <= consume & m_eof;
            if (load) begin
                m_valid <= 1'b1;
                m_red   <= red_hold;
                m_green <= green_hold;
                m_blue  <= s_byte;
                m_sof   <= (row_q == '0) & (col_q == '0);
                m_eol   <= col_last;
                m_eof   <= col_last & row_last;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end else if (consume) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_byte_packer.sv
// Directed bench for rgb_byte_packer: a 4x2 instance and a 1x1 instance share clock/reset.
module tb_rgb_byte_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_byte = '0, b_byte = '0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_mready = 1'b0, b_mready = 1'b0;
    logic       a_ready, b_ready;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_mvalid, a_sof, a_eol, a_eof, a_done;
    logic       b_mvalid, b_sof, b_eol, b_eof, b_done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    rgb_byte_packer #(.width(4), .height(2)) dut_a (
        .clk(clk), .rst(rst), .s_byte(a_byte), .s_valid(a_valid), .s_ready(a_ready),
        .m_red(a_r), .m_green(a_g), .m_blue(a_b), .m_valid(a_mvalid), .m_ready(a_mready),
        .m_sof(a_sof), .m_eol(a_eol), .m_eof(a_eof), .frame_done(a_done)
    );

    rgb_byte_packer #(.width(1), .height(1)) dut_b (
        .clk(clk), .rst(rst), .s_byte(b_byte), .s_valid(b_valid), .s_ready(b_ready),
        .m_red(b_r), .m_green(b_g), .m_blue(b_b), .m_valid(b_mvalid), .m_ready(b_mready),
        .m_sof(b_sof), .m_eol(b_eol), .m_eof(b_eof), .frame_done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Presents one byte and returns #1 after the edge that accepted it.
    task automatic send_a(input logic [7:0] b);
        int unsigned cnt = 0;
        a_byte = b; a_valid = 1'b1;
        @(negedge clk);
        while (!a_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) check("send_a_timeout", 1, 0);
        @(posedge clk); #1 a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        int unsigned cnt = 0;
        b_byte = b; b_valid = 1'b1;
        @(negedge clk);
        while (!b_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) check("send_b_timeout", 1, 0);
        @(posedge clk); #1 b_valid = 1'b0;
    endtask

    function automatic logic [7:0] stream_byte(input int unsigned i);
        return 8'((i * 37 + 5) & 8'hff);
    endfunction

    // Scoreboard for the randomized run: expected pixels follow the byte stream order.
    logic        mon_en = 1'b0;
    int unsigned mon_k = 0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_word = '0;

    always @(negedge clk) begin
        logic [26:0] word, exp;
        int unsigned c, r;
        word = {a_r, a_g, a_b, a_sof, a_eol, a_eof};
        if (mon_en) begin
            if (prev_stall) check("hold_stable", word, prev_word);
            if (a_mvalid && a_mready) begin
                c = mon_k % 4;
                r = (mon_k / 4) % 2;
                exp = {stream_byte(3 * mon_k), stream_byte(3 * mon_k + 1), stream_byte(3 * mon_k + 2),
                       (c == 0 && r == 0), (c == 3), (c == 3 && r == 1)};
                check("rand_pixel", word, exp);
                mon_k++;
            end
        end
        prev_stall = a_mvalid & ~a_mready;
        prev_word  = word;
    end

    initial begin
        logic drv_done;

        // Reset state
        do_reset();
        check("rst_valid_a", a_mvalid, 0);
        check("rst_data_a", {a_r, a_g, a_b, a_sof, a_eol, a_eof, a_done}, 0);
        check("rst_valid_b", b_mvalid, 0);
        check("rst_ready_a", a_ready, 1);

        // First pixel
        a_mready = 1'b1;
        send_a(8'h10); send_a(8'h20); send_a(8'h30);
        check("t1_valid", a_mvalid, 1);
        check("t1_rgb", {a_r, a_g, a_b}, 24'h102030);
        check("t1_flags", {a_sof, a_eol, a_eof}, 3'b100);

        // Full 4x2 frame back-to-back, then start of next frame
        do_reset();
        for (int p = 0; p < 8; p++) begin
            send_a(8'(3 * p)); send_a(8'(3 * p + 1)); send_a(8'(3 * p + 2));
            check("t2_rgb", {a_r, a_g, a_b}, {8'(3 * p), 8'(3 * p + 1), 8'(3 * p + 2)});
            check("t2_flags", {a_sof, a_eol, a_eof}, {p == 0, (p % 4) == 3, p == 7});
        end
        check("t2_done_early", a_done, 0);
        @(posedge clk); #1;
        check("t2_done_pulse", a_done, 1);
        @(posedge clk); #1;
        check("t2_done_clear", a_done, 0);
        send_a(8'h55); send_a(8'h66); send_a(8'h77);
        check("t2_next_sof", {a_sof, a_eol, a_eof}, 3'b100);

        // Backpressure with R,G of the next pixel already accepted
        do_reset();
        a_mready = 1'b0;
        send_a(8'h01); send_a(8'h02); send_a(8'h03);
        send_a(8'h04); send_a(8'h05);
        a_byte = 8'h06; a_valid = 1'b1;
        @(negedge clk);
        check("t3_stall_ready", a_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_held", {a_mvalid, a_r, a_g, a_b, a_sof}, {1'b1, 24'h010203, 1'b1});
        a_mready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", a_ready, 1);
        @(posedge clk); #1 a_valid = 1'b0;
        check("t3_swap", {a_mvalid, a_r, a_g, a_b, a_sof}, {1'b1, 24'h040506, 1'b0});
        @(posedge clk); #1;
        check("t3_drained", a_mvalid, 0);

        // Random gaps and backpressure over three frames
        do_reset();
        mon_en = 1'b1;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 72; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1 send_a(stream_byte(i));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 a_mready = 1'($urandom_range(0, 1));
                end
            end
        join
        a_mready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("t4_count", mon_k, 24);

        // Reset in phase 2 with a pending pixel; reset wins over handshakes
        do_reset();
        a_mready = 1'b0;
        send_a(8'h01); send_a(8'h02); send_a(8'h03);
        send_a(8'h04); send_a(8'h05);
        a_byte = 8'h09; a_valid = 1'b1; a_mready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0;
        check("t5_cleared", {a_mvalid, a_r, a_g, a_b, a_sof, a_eol, a_eof}, 0);
        send_a(8'h07); send_a(8'h08); send_a(8'h09);
        check("t5_pixel", {a_mvalid, a_r, a_g, a_b, a_sof}, {1'b1, 24'h070809, 1'b1});

        // 1x1 frame: every pixel is sof, eol and eof
        b_mready = 1'b1;
        send_b(8'hAA); send_b(8'hBB); send_b(8'hCC);
        check("t6_pixel", {b_mvalid, b_r, b_g, b_b}, {1'b1, 24'hAABBCC});
        check("t6_flags", {b_sof, b_eol, b_eof}, 3'b111);
        @(posedge clk); #1;
        check("t6_done", b_done, 1);
        @(posedge clk); #1;
        check("t6_done_clear", b_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
